// File: rtl/correlating_branch_predictor_v2.sv
// rtl/correlating_branch_predictor_v2.sv - gselect next-PC predictor with speculative history and fully-associative BTB
//
// Purpose: predicts the next fetch PC for a multi-lane fetch block using a
// gselect pattern table indexed by {speculative history, low PC word bits}
// and a fully-associative BTB. It is trained by resolved branches, and the
// history is repaired on a misprediction.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   i_fetch_valid                fetch block at i_pc accepted this cycle
//   i_pc                         current fetch PC (word aligned)
//   o_predicted_pc               next fetch PC
//   o_pc_upperbound              last lane kept in the block (all ones if none is taken)
//   o_predicted_taken            some valid lane is predicted taken
//   o_global_history             speculative history used for this prediction
//   i_branch_valid               resolved branch strobe
//   i_branch_pc                  PC of the resolved branch
//   i_branch_correct_pc_next     actual next PC of the resolved branch
//   i_branch_global_history      history captured when the branch was predicted
//   i_branch_correct_prediction  front end predicted the branch correctly
module correlating_branch_predictor_v2 #(
    parameter int BW_ADDRESS           = 32,
    parameter int BW_PROCESSOR_DATA    = 32,
    parameter int BW_PROCESSOR_BLOCK   = 64,
    parameter int NUM_FIFO_INPUT_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA,
    parameter int BW_PC_MOD            = $clog2(NUM_FIFO_INPUT_ENTRY) + (NUM_FIFO_INPUT_ENTRY <= 1),
    parameter int NUM_GLOBAL_HISTORY   = 4,
    parameter int BW_SELECTED_PC       = 4,
    parameter int BW_COUNTER           = 2,
    parameter int NUM_BTB              = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_fetch_valid,
    input  logic [BW_ADDRESS-1:0]         i_pc,
    output logic [BW_ADDRESS-1:0]         o_predicted_pc,
    output logic [BW_PC_MOD-1:0]          o_pc_upperbound,
    output logic                          o_predicted_taken,
    output logic [NUM_GLOBAL_HISTORY-1:0] o_global_history,
    input  logic                          i_branch_valid,
    input  logic [BW_ADDRESS-1:0]         i_branch_pc,
    input  logic [BW_ADDRESS-1:0]         i_branch_correct_pc_next,
    input  logic [NUM_GLOBAL_HISTORY-1:0] i_branch_global_history,
    input  logic                          i_branch_correct_prediction
);

    localparam int BW_WORD    = BW_ADDRESS - 2;
    localparam int BW_PHT_IDX = NUM_GLOBAL_HISTORY + BW_SELECTED_PC;
    localparam int NUM_PHT    = 1 << BW_PHT_IDX;
    localparam int BW_BTB_IDX = (NUM_BTB > 1) ? $clog2(NUM_BTB) : 1;
    localparam int H          = NUM_GLOBAL_HISTORY;

    localparam logic [BW_COUNTER-1:0] CNT_INIT = BW_COUNTER'((1 << (BW_COUNTER - 1)) - 1);
    localparam logic [BW_COUNTER-1:0] CNT_MAX  = {BW_COUNTER{1'b1}};
    localparam logic [BW_BTB_IDX-1:0] RR_LAST  = BW_BTB_IDX'(NUM_BTB - 1);

    // State
    logic [H-1:0]          ghist_q, ghist_d;
    logic [BW_COUNTER-1:0] pht_q [NUM_PHT];
    logic                  btb_valid_q  [NUM_BTB];
    logic [BW_WORD-1:0]    btb_tag_q    [NUM_BTB];
    logic [BW_WORD-1:0]    btb_target_q [NUM_BTB];
    logic [BW_BTB_IDX-1:0] rr_q, rr_d;

    // ---------------- Prediction ----------------
    logic [BW_WORD-1:0]    block_word;
    logic [BW_PC_MOD-1:0]  start_lane;
    logic [BW_WORD-1:0]    lane_word;
    logic [BW_PHT_IDX-1:0] lane_idx;
    logic                  lane_hit;
    logic [BW_WORD-1:0]    lane_target;
    logic                  found;
    logic [BW_WORD-1:0]    pred_word;
    logic [BW_PC_MOD-1:0]  upperbound;

    assign block_word = {i_pc[BW_ADDRESS-1:BW_PC_MOD+2], {BW_PC_MOD{1'b0}}};
    assign start_lane = i_pc[BW_PC_MOD+1:2];

    always_comb begin
        found       = 1'b0;
        pred_word   = block_word + BW_WORD'(NUM_FIFO_INPUT_ENTRY);
        upperbound  = {BW_PC_MOD{1'b1}};
        lane_word   = '0;
        lane_idx    = '0;
        lane_hit    = 1'b0;
        lane_target = '0;
        for (int i = 0; i < NUM_FIFO_INPUT_ENTRY; i++) begin
            lane_word   = block_word + BW_WORD'(i);
            lane_idx    = {ghist_q, lane_word[BW_SELECTED_PC-1:0]};
            lane_hit    = 1'b0;
            lane_target = '0;
            // Descending scan so the lowest matching entry supplies the target.
            for (int e = NUM_BTB - 1; e >= 0; e--) begin
                if (btb_valid_q[e] && (btb_tag_q[e] == lane_word)) begin
                    lane_hit    = 1'b1;
                    lane_target = btb_target_q[e];
                end
            end
            if (!found && (BW_PC_MOD'(i) >= start_lane) &&
                pht_q[lane_idx][BW_COUNTER-1] && lane_hit) begin
                found      = 1'b1;
                pred_word  = lane_target;
                upperbound = BW_PC_MOD'(i);
            end
        end
    end

    assign o_predicted_pc    = {pred_word, 2'b00};
    assign o_pc_upperbound   = upperbound;
    assign o_predicted_taken = found;
    assign o_global_history  = ghist_q;

    // ---------------- Resolve ----------------
    logic [BW_WORD-1:0]    br_word;
    logic [BW_WORD-1:0]    nx_word;
    logic                  correct_taken;
    logic [BW_PHT_IDX-1:0] upd_idx;
    logic [BW_COUNTER-1:0] cnt_d;
    logic                  btb_hit;
    logic [BW_BTB_IDX-1:0] btb_hit_idx;
    logic                  btb_free;
    logic [BW_BTB_IDX-1:0] btb_free_idx;
    logic [BW_BTB_IDX-1:0] btb_wr_idx;

    assign br_word       = i_branch_pc[BW_ADDRESS-1:2];
    assign nx_word       = i_branch_correct_pc_next[BW_ADDRESS-1:2];
    // Anything other than the sequential successor counts as taken.
    assign correct_taken = (nx_word != (br_word + BW_WORD'(1)));
    assign upd_idx       = {i_branch_global_history, br_word[BW_SELECTED_PC-1:0]};

    always_comb begin
        cnt_d = pht_q[upd_idx];
        if (correct_taken && (pht_q[upd_idx] != CNT_MAX)) begin
            cnt_d = pht_q[upd_idx] + BW_COUNTER'(1);
        end else if (!correct_taken && (pht_q[upd_idx] != '0)) begin
            cnt_d = pht_q[upd_idx] - BW_COUNTER'(1);
        end
    end

    always_comb begin
        btb_hit      = 1'b0;
        btb_hit_idx  = '0;
        btb_free     = 1'b0;
        btb_free_idx = '0;
        for (int e = NUM_BTB - 1; e >= 0; e--) begin
            if (btb_valid_q[e] && (btb_tag_q[e] == br_word)) begin
                btb_hit     = 1'b1;
                btb_hit_idx = BW_BTB_IDX'(e);
            end
            if (!btb_valid_q[e]) begin
                btb_free     = 1'b1;
                btb_free_idx = BW_BTB_IDX'(e);
            end
        end
        if (btb_hit) begin
            btb_wr_idx = btb_hit_idx;
        end else if (btb_free) begin
            btb_wr_idx = btb_free_idx;
        end else begin
            btb_wr_idx = rr_q;
        end
    end

    // Round-robin pointer moves only when a full table forces an eviction.
    always_comb begin
        rr_d = rr_q;
        if (i_branch_valid && correct_taken && !btb_hit && !btb_free) begin
            rr_d = (rr_q == RR_LAST) ? '0 : rr_q + BW_BTB_IDX'(1);
        end
    end

    // Misprediction repair overrides the fetch-time speculative shift.
    always_comb begin
        ghist_d = ghist_q;
        if (i_branch_valid && !i_branch_correct_prediction) begin
            ghist_d = {i_branch_global_history[H-2:0], correct_taken};
        end else if (i_fetch_valid && found) begin
            ghist_d = {ghist_q[H-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghist_q <= '0;
            rr_q    <= '0;
            for (int p = 0; p < NUM_PHT; p++) begin
                pht_q[p] <= CNT_INIT;
            end
            for (int e = 0; e < NUM_BTB; e++) begin
                btb_valid_q[e]  <= 1'b0;
                btb_tag_q[e]    <= '0;
                btb_target_q[e] <= '0;
            end
        end else begin
            ghist_q <= ghist_d;
            rr_q    <= rr_d;
            if (i_branch_valid) begin
                pht_q[upd_idx] <= cnt_d;
                if (correct_taken) begin
                    btb_valid_q[btb_wr_idx]  <= 1'b1;
                    btb_tag_q[btb_wr_idx]    <= br_word;
                    btb_target_q[btb_wr_idx] <= nx_word;
                end
            end
        end
    end

    wire unused_bits = ^{i_pc[1:0], i_branch_pc[1:0], i_branch_correct_pc_next[1:0]};

endmodule

// File: doc/correlating_branch_predictor_v2.md
Name: correlating_branch_predictor_v2

Overview:
Second-generation gselect branch predictor for the PC stage. It predicts the next fetch PC for a multi-instruction fetch block. A global history that is updated speculatively at fetch is repaired from the branch unit on a misprediction. The pattern table uses saturating counters of configurable width, and the fully-associative BTB retargets entries on a hit and uses round-robin replacement when full. It sits between the PC register and instruction memory, and is trained by resolved branches from the branch unit.

Parameters:
BW_ADDRESS, 32, PC width in bits.
BW_PROCESSOR_DATA, 32, width of one instruction.
BW_PROCESSOR_BLOCK, 64, width of one fetch block.
NUM_FIFO_INPUT_ENTRY, BW_PROCESSOR_BLOCK/BW_PROCESSOR_DATA, lanes per fetch block (derived).
BW_PC_MOD, $clog2(NUM_FIFO_INPUT_ENTRY)+(NUM_FIFO_INPUT_ENTRY<=1), lane index width (derived).
NUM_GLOBAL_HISTORY, 4, global history length H (H>=2).
BW_SELECTED_PC, 4, PC bits S used in the PHT index.
BW_COUNTER, 2, saturating counter width C (C>=1).
NUM_BTB, 8, number of BTB entries (>=1).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_fetch_valid  input  1  the fetch block at i_pc is accepted this cycle
i_pc  input  BW_ADDRESS  current fetch PC, word aligned
o_predicted_pc  output  BW_ADDRESS  next fetch PC
o_pc_upperbound  output  BW_PC_MOD  last lane to keep in the block; all ones if no lane is predicted taken
o_predicted_taken  output  1  some valid lane is predicted taken
o_global_history  output  H  speculative history used for this prediction
i_branch_valid  input  1  resolved branch strobe
i_branch_pc  input  BW_ADDRESS  PC of the resolved branch
i_branch_correct_pc_next  input  BW_ADDRESS  actual next PC
i_branch_global_history  input  H  history captured when the branch was predicted
i_branch_correct_prediction  input  1  the front end predicted this branch correctly

Behaviour:
- Reset (async, rst_n=0):
  - spec_ghist=0.
  - All BTB valid bits=0.
  - Round-robin pointer=0.
  - Every PHT counter = 2^(C-1)-1 (weakly not-taken).
  - Outputs are combinational from this state, so after reset o_predicted_taken=0 and o_predicted_pc = aligned block base + NUM_FIFO_INPUT_ENTRY*4.
- Prediction (combinational, 0 cycles):
  - Lane i PC = {i_pc[BW_ADDRESS-1:BW_PC_MOD+2], 0} + 4i.
  - A lane is valid when i >= i_pc[BW_PC_MOD+1:2].
  - PHT index = {spec_ghist, laneword[S-1:0]}; the table has 2^(H+S) entries.
  - Predicted taken = counter MSB.
  - A lane is "taken" when it is valid, predicted taken, and hits in the BTB (valid entry, tag = PC>>2).
  - The lowest taken lane wins: o_pc_upperbound = its index, o_predicted_pc = its BTB target<<2, o_predicted_taken=1.
  - If no lane is taken: upperbound all ones, o_predicted_pc = block base + NUM_FIFO_INPUT_ENTRY*4.
- Speculative history (registered):
  - On a cycle where i_fetch_valid and o_predicted_taken are both 1: spec_ghist <= {spec_ghist[H-2:0],1}.
  - Otherwise spec_ghist is unchanged.
- Resolve (registered, takes effect on the next edge when i_branch_valid=1):
  - correct_taken = (i_branch_correct_pc_next>>2) != (i_branch_pc>>2)+1.
  - Repair: if i_branch_correct_prediction=0, spec_ghist <= {i_branch_global_history[H-2:0], correct_taken}. Repair has priority over a same-cycle fetch shift.
  - PHT update: the counter at {i_branch_global_history, (i_branch_pc>>2)[S-1:0]} saturating-increments if correct_taken, otherwise saturating-decrements. It is clamped at 0 and 2^C-1.
  - BTB, only when correct_taken:
    - On a hit, overwrite the target (no duplicate entry).
    - On a miss, insert at the lowest invalid entry.
    - If no entry is invalid, insert at the round-robin pointer, then pointer <= (pointer+1) mod NUM_BTB.
    - The pointer advances only on a full-table replacement.
  - BTB, when correct_taken=0: no BTB change.
- Same-cycle read/update: prediction sees pre-update state; updates become visible the next cycle.
- A reset asserted mid-operation overrides any pending update.

Test Plan:
- Reset, i_pc=0x100 -> o_predicted_pc=0x108, o_pc_upperbound=1, o_predicted_taken=0, o_global_history=0.
- Two resolves: pc=0x104, next=0x200, hist=0, correct_prediction=1; then i_pc=0x100 -> counter at index 1 = 3, o_predicted_pc=0x200, upperbound=1, taken=1. Same with i_pc=0x104. Assert i_fetch_valid -> o_global_history=0001 next cycle.
- spec_ghist=0101; resolve hist=0011, pc=0x40, next=0x44, correct_prediction=0, while a taken fetch is accepted in the same cycle -> spec_ghist=0110 (repair wins).
- Counter at 3, taken resolve -> stays 3. One not-taken resolve -> 2, still predicts taken. Second not-taken -> 1, lane falls through to PC+8 block.
- Fill 8 distinct taken branches 0x1000..0x101C. A 9th at 0x2000 replaces entry 0 and the pointer becomes 1. A 10th replaces entry 1. A lookup of 0x1000 then misses.
- Hit at 0x104 with new target 0x300 -> entry retargeted, valid count unchanged, prediction is 0x300 next cycle.
